// File: rtl/memory_write_ctrl_if.sv
// Block-format constants shared with memory_read_ctrl, and the byte/allocator/SRAM
// bundle of memory_write_ctrl (master = the controller, slave = its environment).
package mem_pkg;
  localparam int BLOCK_BITS = 80;
  localparam int ADDR_W     = 12;
  localparam int P          = (BLOCK_BITS - 16) / 8;

  // Occupies bits [15:0] of every block; the read side walks next_idx until eop.
  typedef struct packed {
    logic [ADDR_W-1:0]    next_idx;
    logic                 eop;
    logic [14-ADDR_W:0]   rsvd;
  } footer_t;
endpackage

interface memory_write_ctrl_if;
  logic                          data_i_valid_unused_guard;
  logic [7:0]                    data_i;
  logic                          data_valid_i;
  logic                          data_last_i;
  logic                          ready_o;
  logic                          alloc_req_o;
  logic                          alloc_gnt_i;
  logic [mem_pkg::ADDR_W-1:0]    alloc_idx_i;
  logic                          mem_we_o;
  logic [mem_pkg::ADDR_W-1:0]    mem_waddr_o;
  logic [mem_pkg::BLOCK_BITS-1:0] mem_wdata_o;
  logic                          frame_done_o;
  logic [mem_pkg::ADDR_W-1:0]    head_idx_o;
  logic [15:0]                   frame_len_o;

  modport master (
    input  data_i, data_valid_i, data_last_i, alloc_gnt_i, alloc_idx_i,
    output ready_o, alloc_req_o, mem_we_o, mem_waddr_o, mem_wdata_o,
           frame_done_o, head_idx_o, frame_len_o
  );

  modport slave (
    output data_i, data_valid_i, data_last_i, alloc_gnt_i, alloc_idx_i,
    input  ready_o, alloc_req_o, mem_we_o, mem_waddr_o, mem_wdata_o,
           frame_done_o, head_idx_o, frame_len_o
  );
endinterface

// File: rtl/memory_write_ctrl.sv
// Packs a byte-serial frame into linked SRAM blocks taken from the free-list
// allocator, then reports the frame's head block index and byte length.
module memory_write_ctrl
  import mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  memory_write_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ALLOC_HEAD,
    FILL,
    ALLOC_LINK
  } state_t;

  localparam int PTR_W = (P > 1) ? $clog2(P) : 1;
  localparam int PAY_W = P * 8;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_ready;
  logic                w_alloc_req;
  logic                w_accept;
  logic                w_grant;
  logic                w_blk_full;
  logic [PAY_W-1:0]    w_buf_wr;

  logic [ADDR_W-1:0]   r_cur_idx;
  logic [ADDR_W-1:0]   r_head_idx;
  logic [PTR_W-1:0]    r_ptr;
  logic [15:0]         r_len;
  logic [PAY_W-1:0]    r_buf;

  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [BLOCK_BITS-1:0] r_wdata;
  logic                r_done;
  logic [ADDR_W-1:0]   r_head_o;
  logic [15:0]         r_len_o;

  function automatic footer_t make_footer(input logic [ADDR_W-1:0] next_idx, input logic eop);
    footer_t f;
    f.next_idx = next_idx;
    f.eop      = eop;
    f.rsvd     = '0;
    return f;
  endfunction

  assign w_accept   = bus.data_valid_i & w_ready;
  assign w_grant    = bus.alloc_gnt_i & w_alloc_req;
  assign w_blk_full = (r_ptr == PTR_W'(P - 1));

  // Byte k of a block sits at the top of the word, so the payload fills MSB-first.
  always_comb begin
    w_buf_wr = r_buf;
    w_buf_wr[(P - 1 - int'(r_ptr)) * 8 +: 8] = bus.data_i;
  end

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= ALLOC_HEAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_alloc_req = 1'b0;
    case (r_state)
      ALLOC_HEAD: begin
        w_alloc_req = !rst;
        if (bus.alloc_gnt_i && !rst) w_state_nxt = FILL;
      end
      FILL: begin
        w_ready = 1'b1;
        if (bus.data_valid_i) begin
          if (bus.data_last_i)  w_state_nxt = ALLOC_HEAD;
          else if (w_blk_full)  w_state_nxt = ALLOC_LINK;
        end
      end
      ALLOC_LINK: begin
        w_alloc_req = !rst;
        if (bus.alloc_gnt_i && !rst) w_state_nxt = FILL;
      end
      default: w_state_nxt = ALLOC_HEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_idx  <= '0;
      r_head_idx <= '0;
      r_ptr      <= '0;
      r_len      <= '0;
      r_buf      <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_head_o   <= '0;
      r_len_o    <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ALLOC_HEAD: begin
          if (w_grant) begin
            r_cur_idx  <= bus.alloc_idx_i;
            r_head_idx <= bus.alloc_idx_i;
            r_ptr      <= '0;
            r_len      <= '0;
            r_buf      <= '0;
          end
        end
        FILL: begin
          if (w_accept) begin
            r_len <= r_len + 16'd1;
            if (bus.data_last_i) begin
              // Unwritten positions are still zero from the last buffer clear.
              r_we     <= 1'b1;
              r_waddr  <= r_cur_idx;
              r_wdata  <= {w_buf_wr, make_footer('0, 1'b1)};
              r_done   <= 1'b1;
              r_head_o <= r_head_idx;
              r_len_o  <= r_len + 16'd1;
              r_buf    <= '0;
              r_ptr    <= '0;
            end else if (w_blk_full) begin
              r_buf <= w_buf_wr;
            end else begin
              r_buf <= w_buf_wr;
              r_ptr <= r_ptr + PTR_W'(1);
            end
          end
        end
        ALLOC_LINK: begin
          if (w_grant) begin
            r_we      <= 1'b1;
            r_waddr   <= r_cur_idx;
            r_wdata   <= {r_buf, make_footer(bus.alloc_idx_i, 1'b0)};
            r_cur_idx <= bus.alloc_idx_i;
            r_buf     <= '0;
            r_ptr     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o      = w_ready;
  assign bus.alloc_req_o  = w_alloc_req;
  assign bus.mem_we_o     = r_we;
  assign bus.mem_waddr_o  = r_waddr;
  assign bus.mem_wdata_o  = r_wdata;
  assign bus.frame_done_o = r_done;
  assign bus.head_idx_o   = r_head_o;
  assign bus.frame_len_o  = r_len_o;

endmodule

// File: tb/tb_memory_write_ctrl.sv
// Bench for memory_write_ctrl: directed and random frames against a block-chunking
// model, plus a chain walk over a modelled SRAM.
module tb_memory_write_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  memory_write_ctrl_if bus ();

  memory_write_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int                    addr;
    logic [BLOCK_BITS-1:0] data;
    int                    cyc;
  } wr_t;

  typedef struct {
    int head;
    int len;
    int cyc;
    int req;
  } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  logic [BLOCK_BITS-1:0] sram [0:4095];

  int grant_q[$];
  int delay_q[$];
  int grant_log[$];
  int grant_cyc[$];
  int wait_cnt    = 0;
  int wait_cycles = 0;
  int wait_bad    = 0;

  task automatic check(input string tag, input logic [BLOCK_BITS-1:0] obs,
                       input logic [BLOCK_BITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write/done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t   w;
    done_t d;
    if (bus.mem_we_o) begin
      w.addr = int'(bus.mem_waddr_o);
      w.data = bus.mem_wdata_o;
      w.cyc  = cycle;
      wr_q.push_back(w);
      sram[bus.mem_waddr_o] <= bus.mem_wdata_o;
    end
    if (bus.frame_done_o) begin
      d.head = int'(bus.head_idx_o);
      d.len  = int'(bus.frame_len_o);
      d.cyc  = cycle;
      d.req  = int'(bus.alloc_req_o);
      done_q.push_back(d);
    end
  end

  // Allocator: answers requests from grant_q after a per-grant delay.
  initial begin
    bus.alloc_gnt_i = 1'b0;
    bus.alloc_idx_i = '0;
    forever begin
      @(negedge clk);
      bus.alloc_gnt_i = 1'b0;
      if (!rst && bus.alloc_req_o && grant_q.size() > 0) begin
        if (wait_cnt < delay_q[0]) begin
          if (bus.ready_o || (bus.mem_we_o && wait_cnt > 0)) wait_bad++;
          wait_cnt++;
          wait_cycles++;
        end else begin
          bus.alloc_gnt_i = 1'b1;
          bus.alloc_idx_i = ADDR_W'(grant_q.pop_front());
          void'(delay_q.pop_front());
          grant_log.push_back(int'(bus.alloc_idx_i));
          grant_cyc.push_back(cycle + 1);
          wait_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Expected block i: P consecutive frame bytes from the top, zero-padded, then footer.
  function automatic logic [BLOCK_BITS-1:0] exp_block(input logic [7:0] b[$], input int blk,
                                                      input int next, input bit eop);
    logic [BLOCK_BITS-1:0] w = '0;
    footer_t f;
    for (int k = 0; k < P; k++) begin
      int j = blk * P + k;
      if (j < b.size()) w[BLOCK_BITS-1-8*k -: 8] = b[j];
    end
    f.next_idx = ADDR_W'(next);
    f.eop      = eop;
    f.rsvd     = '0;
    w[15:0]    = f;
    return w;
  endfunction

  task automatic send_frame(input logic [7:0] b[$], input bit with_last, output bit ok,
                            output int first_ready_cyc, output int acc_cyc);
    int budget = 0;
    ok = 1'b1;
    first_ready_cyc = -1;
    acc_cyc = -1;
    for (int i = 0; i < b.size(); i++) begin
      @(negedge clk);
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        bus.data_valid_i = 1'b0;
        bus.data_last_i  = 1'b0;
        @(negedge clk);
      end
      bus.data_i       = b[i];
      bus.data_valid_i = 1'b1;
      bus.data_last_i  = with_last && (i == b.size() - 1);
      while (!bus.ready_o && budget < 500) begin
        @(negedge clk);
        budget++;
      end
      if (!bus.ready_o) begin
        ok = 1'b0;
        break;
      end
      if (first_ready_cyc < 0) first_ready_cyc = cycle;
      acc_cyc = cycle + 1;
    end
    @(negedge clk);
    bus.data_valid_i = 1'b0;
    bus.data_last_i  = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b[$], input int g[$],
                           input int hdly, input int ldly);
    int  n, nblk, t, frc, acc;
    bit  ok;
    wr_q.delete();
    done_q.delete();
    grant_log.delete();
    grant_cyc.delete();
    grant_q.delete();
    delay_q.delete();
    wait_cnt    = 0;
    wait_cycles = 0;
    wait_bad    = 0;
    foreach (g[i]) begin
      grant_q.push_back(g[i]);
      delay_q.push_back(i == 0 ? hdly : ldly);
    end
    send_frame(b, 1'b1, ok, frc, acc);
    t = 0;
    while (done_q.size() == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);

    n    = b.size();
    nblk = (n + P - 1) / P;
    check({tag, ".tx_ok"},    ok, 1);
    check({tag, ".grants"},   grant_log.size(), nblk);
    check({tag, ".writes"},   wr_q.size(), nblk);
    check({tag, ".done_cnt"}, done_q.size(), 1);
    if (grant_cyc.size() > 0) check({tag, ".head_ready_cyc"}, frc, grant_cyc[0]);
    if (done_q.size() > 0) begin
      check({tag, ".head"},     done_q[0].head, g[0]);
      check({tag, ".len"},      done_q[0].len, n & 16'hFFFF);
      check({tag, ".done_cyc"}, done_q[0].cyc, acc);
      check({tag, ".req_after_done"}, done_q[0].req, 1);
    end
    for (int i = 0; i < nblk && i < wr_q.size(); i++) begin
      bit last_blk = (i == nblk - 1);
      check($sformatf("%s.addr%0d", tag, i), wr_q[i].addr, g[i]);
      check($sformatf("%s.data%0d", tag, i), wr_q[i].data,
            exp_block(b, i, last_blk ? 0 : g[i+1], last_blk));
      check($sformatf("%s.wcyc%0d", tag, i), wr_q[i].cyc,
            last_blk ? acc : ((i + 1 < grant_cyc.size()) ? grant_cyc[i+1] : -1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ready"},  bus.ready_o, 0);
    check({tag, ".req"},    bus.alloc_req_o, 0);
    check({tag, ".we"},     bus.mem_we_o, 0);
    check({tag, ".done"},   bus.frame_done_o, 0);
    check({tag, ".waddr"},  bus.mem_waddr_o, 0);
    check({tag, ".wdata"},  bus.mem_wdata_o, 0);
    check({tag, ".head"},   bus.head_idx_o, 0);
    check({tag, ".len"},    bus.frame_len_o, 0);
  endtask

  initial begin
    logic [7:0] bq[$];
    logic [7:0] chain_bytes[$];
    int         gq[$];
    int         chain_g[10] = '{37, 905, 128, 2047, 319, 4093, 777, 2560, 1234, 3001};
    bit         ok;
    int         frc, acc, idx, nblk, len;
    logic [BLOCK_BITS-1:0] blk;
    logic [BLOCK_BITS-17:0] exp_pay;
    footer_t    f;

    bus.data_i       = '0;
    bus.data_valid_i = 1'b0;
    bus.data_last_i  = 1'b0;

    // Reset state and first request.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset.req",   bus.alloc_req_o, 1);
    check("post_reset.ready", bus.ready_o, 0);

    // Single-byte frame.
    bq.delete(); bq.push_back(8'hA5);
    gq.delete(); gq.push_back(37);
    run_frame("single", bq, gq, 0, 0);

    // Exactly P bytes: one block, no link allocation.
    bq.delete(); for (int i = 0; i < P; i++) bq.push_back(8'($urandom));
    gq.delete(); gq.push_back(37);
    run_frame("exact_p", bq, gq, 0, 0);

    // P+1 bytes across two blocks.
    bq.delete(); for (int i = 0; i < P + 1; i++) bq.push_back(8'($urandom));
    gq.delete(); gq.push_back(37); gq.push_back(905);
    run_frame("p_plus1", bq, gq, 0, 0);

    // Link grant withheld for 10 cycles.
    bq.delete(); for (int i = 0; i < P + 3; i++) bq.push_back(8'($urandom));
    gq.delete(); gq.push_back(50); gq.push_back(60);
    run_frame("withheld", bq, gq, 0, 10);
    check("withheld.wait_cycles", wait_cycles, 10);
    check("withheld.wait_bad",    wait_bad, 0);

    // Ten-block chain, then walk it from the head through the modelled SRAM.
    chain_bytes.delete(); for (int i = 0; i < 10 * P; i++) chain_bytes.push_back(8'($urandom));
    gq.delete(); foreach (chain_g[i]) gq.push_back(chain_g[i]);
    run_frame("chain", chain_bytes, gq, 1, 2);
    idx = 37;
    for (int s = 0; s < 10; s++) begin
      blk = sram[idx];
      f   = footer_t'(blk[15:0]);
      for (int k = 0; k < P; k++) exp_pay[(P-1-k)*8 +: 8] = chain_bytes[s*P + k];
      check($sformatf("walk.idx%0d", s), idx, chain_g[s]);
      check($sformatf("walk.pay%0d", s), blk[BLOCK_BITS-1:16], exp_pay);
      check($sformatf("walk.eop%0d", s), f.eop, (s == 9));
      idx = int'(f.next_idx);
    end
    check("walk.end_next", idx, 0);

    // Reset after three bytes in FILL.
    bq.delete(); for (int i = 0; i < 3; i++) bq.push_back(8'($urandom));
    gq.delete(); grant_q.delete(); delay_q.delete(); wr_q.delete(); done_q.delete();
    grant_q.push_back(100); delay_q.push_back(0);
    send_frame(bq, 1'b0, ok, frc, acc);
    check("rst_mid.tx_ok", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    check("rst_mid.no_write", wr_q.size(), 0);
    rst = 1'b0;
    bq.delete(); for (int i = 0; i < P + 2; i++) bq.push_back(8'($urandom));
    gq.delete(); gq.push_back(200); gq.push_back(201);
    run_frame("after_rst", bq, gq, 0, 0);

    // Random frames with random allocator latency.
    for (int fr = 0; fr < 15; fr++) begin
      len  = $urandom_range(1, 3 * P + 1);
      nblk = (len + P - 1) / P;
      bq.delete(); for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
      gq.delete(); for (int i = 0; i < nblk; i++) gq.push_back($urandom_range(0, 4095));
      run_frame($sformatf("rnd%0d", fr), bq, gq, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_write_ctrl.md
# memory_write_ctrl

Upstream stage of `memory_read_ctrl`: packs an incoming byte-serial frame into fixed-size SRAM blocks. Block indices come from the free-list allocator. Blocks are linked through the `footer_t` in bits [15:0] of each block, so `memory_read_ctrl` can walk the chain from the head index. On frame completion it reports the head index and byte length, for the queue that later issues `start`/`start_addr_i` to the read side.

## Interface

Parameters (from `mem_pkg`, not overridable):
- `BLOCK_BITS`, pkg value: SRAM word width; (BLOCK_BITS-16) must be a multiple of 8.
- `ADDR_W`, pkg value (12): block index width.
- `P`, derived (BLOCK_BITS-16)/8: payload bytes per block.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `data_i`  in  8  frame byte.
- `data_valid_i`  in  1  byte valid.
- `data_last_i`  in  1  final byte of frame, qualified by `data_valid_i`.
- `ready_o`  out  1  byte accepted when `data_valid_i & ready_o`.
- `alloc_req_o`  out  1  request one free block index.
- `alloc_gnt_i`  in  1  grant pulse; valid only while `alloc_req_o`=1.
- `alloc_idx_i`  in  ADDR_W  granted index, valid with `alloc_gnt_i`.
- `mem_we_o`  out  1  SRAM write strobe; one block written per strobe.
- `mem_waddr_o`  out  ADDR_W  block index written.
- `mem_wdata_o`  out  BLOCK_BITS  payload plus footer.
- `frame_done_o`  out  1  one-cycle pulse when the frame's last block is written.
- `head_idx_o`  out  ADDR_W  first block index of the completed frame.
- `frame_len_o`  out  16  byte count of the completed frame.

## Operation

- States: ALLOC_HEAD, FILL, ALLOC_LINK.
- Reset entry: state ALLOC_HEAD; byte counter, frame length and payload buffer cleared.
- `alloc_req_o` = (state is ALLOC_HEAD or ALLOC_LINK) and !rst.
- `ready_o` = (state is FILL).
- A block index held at reset mid-frame is leaked; this is accepted.
- **ALLOC_HEAD**, on grant:
  - `cur_idx`, `head_idx` <= `alloc_idx_i`; byte pointer <= 0; length <= 0.
  - Go to FILL.
- **FILL**, on each accepted byte:
  - Byte k of the block goes to bits [BLOCK_BITS-1-8k -: 8].
  - Byte pointer and length increment by 1.
- **FILL**, accepted byte with `data_last_i`=1, at any pointer:
  - Write block at `cur_idx`: unused payload bytes zero; footer next_idx=0, eop=1, rsvd=0.
  - Pulse `frame_done_o` with `head_idx`, final length.
  - Go to ALLOC_HEAD.
- **FILL**, accepted byte that fills position P-1 with `data_last_i`=0:
  - Go to ALLOC_LINK and hold the full buffer.
- **ALLOC_LINK**, on grant:
  - Write buffer at `cur_idx` with footer next_idx=`alloc_idx_i`, eop=0, rsvd=0.
  - `cur_idx` <= `alloc_idx_i`; clear buffer and pointer.
  - Go to FILL.
- A frame whose last byte lands exactly at position P-1 needs no extra allocation.
- Length is 16-bit and wraps. Frames over 65535 bytes are unsupported.
- `alloc_gnt_i` while `alloc_req_o`=0 is ignored.

## Timing

- Reset values: `ready_o`=0, `alloc_req_o`=0, `mem_we_o`=0, `frame_done_o`=0; `mem_waddr_o`, `mem_wdata_o`, `head_idx_o`, `frame_len_o` = 0.
- `alloc_req_o` is high from the first cycle after `rst` deasserts.
- A grant may arrive in the same cycle the request rises; zero-wait allocators are supported.
- Grant sampled in cycle N:
  - From ALLOC_HEAD: `ready_o`=1 in N+1.
  - From ALLOC_LINK: the link write (`mem_we_o`) appears in N+1, and `ready_o`=1 in the same N+1.
- Last byte accepted in cycle N: `mem_we_o` and `frame_done_o` high in N+1 only; `alloc_req_o` high from N+1.
- `mem_we_o`, `mem_waddr_o`, `mem_wdata_o`, `frame_done_o`, `head_idx_o`, `frame_len_o` are registered.
- `mem_we_o` is at most one cycle per block. The SRAM never back-pressures.
- FILL throughput: 1 byte/cycle.
- Block-crossing cost: 1 cycle, plus allocator wait.
- Between frames: at least 1 cycle dead time, plus allocator wait.
- `rst` high in any cycle: all outputs return to reset values in the next cycle, regardless of state.

## Test plan

- Single-byte frame:
  - Stimulus: grant 37, then byte 0xA5 with last.
  - Response: one write to addr 37, wdata top byte 0xA5, other payload 0, footer {next=0, eop=1}; `frame_done_o` with head=37, len=1.
- Exactly P bytes, grant 37:
  - One write, eop=1.
  - No `alloc_req_o` in ALLOC_LINK; the next request is ALLOC_HEAD after `frame_done_o`.
  - len=P.
- P+1 bytes, grants 37 then 905:
  - Write to 37 with footer {next=905, eop=0}, then write to 905 with byte 0 at the top and eop=1.
  - head=37, len=P+1.
- Grant withheld 10 cycles in ALLOC_LINK:
  - `ready_o`=0 and `alloc_req_o`=1 throughout, no `mem_we_o`, buffer preserved.
  - On grant, the write appears next cycle with the correct data.
- Chain round-trip:
  - Grants 37, 905, 128, 2047, 319, 4093, 777, 2560, 1234, 3001 for a 10·P-byte frame into `sram`.
  - Then `memory_read_ctrl` started at 37 returns 10 blocks in order, with eop only on 3001, and payload matching input.
- Reset mid-frame:
  - Stimulus: `rst` pulsed after 3 bytes in FILL.
  - Response: next cycle all outputs at reset values, no write issued; the next frame starts with a fresh ALLOC_HEAD and len counted from 0.
